axi_stream_cache_param: RTL and testbench
=========================================

Name: axi_stream_cache_param

Overview:
- Parametrised single-clock AXI-Stream FIFO cache, the successor to the fixed 72-bit / 512-deep cache.
- Width, depth and almost thresholds are configurable.
- Adds fill-level and almost flags, plus an optional packet (store-and-forward) mode with a deadlock-free fallback for oversize packets.
- Sits between AXI-Stream producers and consumers in the same clock domain. Use it for rate smoothing or whole-packet buffering ahead of arbiters and muxes.

Parameters:
DSIZE, 64, tdata width in bits (1..1024)
DEPTH, 512, storage entries; power of two, >= 4
PACKET_MODE, 0, 0 = cut-through FWFT; 1 = store-and-forward on tlast
ALMOST_FULL_OFFSET, 16, almost_full when free entries <= this value
ALMOST_EMPTY_OFFSET, 16, almost_empty when count <= this value

Ports:
aclk  input  1  clock
rst  input  1  asynchronous active-high reset
aclken  input  1  clock enable; when low, no state changes and no handshakes complete
axis_in_tdata  input  DSIZE  write data
axis_in_tlast  input  1  end-of-packet marker, stored with the data
axis_in_tvalid  input  1  write request
axis_in_tready  output  1  FIFO can accept a beat
axis_out_tdata  output  DSIZE  head-of-FIFO data
axis_out_tlast  output  1  head-of-FIFO tlast
axis_out_tvalid  output  1  head beat is presentable
axis_out_tready  input  1  consumer accepts
count  output  $clog2(DEPTH+1)  stored beats
pkt_count  output  $clog2(DEPTH+1)  complete packets stored
almost_full  output  1  see ALMOST_FULL_OFFSET
almost_empty  output  1  see ALMOST_EMPTY_OFFSET
oversize  output  1  sticky; set when the oversize fallback fires

Behaviour:
- Reset (asynchronous on rst rising; released synchronously to aclk):
  - pointers, count, pkt_count, force and oversize = 0
  - axis_in_tready = 1, axis_out_tvalid = 0, almost_empty = 1, almost_full = 0
- Write: a beat is stored when axis_in_tvalid && axis_in_tready && aclken at a rising edge.
- Read: a beat is consumed when axis_out_tvalid && axis_out_tready && aclken at a rising edge.
- axis_in_tready = (count != DEPTH). It is registered and does not depend on axis_out_tready in the same cycle (no full-bypass).
  - Read at full: tready rises on the cycle after the read.
- FWFT: axis_out_tdata / axis_out_tlast always show the head entry. Contents are undefined when count == 0.
- Latency, PACKET_MODE = 0: a beat written at edge N is presentable (tvalid = 1) from edge N+1. Write into empty gives 1-cycle latency.
- axis_out_tvalid, PACKET_MODE = 0: (count != 0).
- axis_out_tvalid, PACKET_MODE = 1: (count != 0) && (pkt_count != 0 || force).
  - A packet becomes visible on the edge after its tlast beat is written.
- pkt_count:
  - +1 on a write with tlast, -1 on a read with tlast.
  - Both in one cycle: unchanged.
  - Tied to 0 when PACKET_MODE = 0.
- Oversize fallback (PACKET_MODE = 1):
  - If count == DEPTH && pkt_count == 0, force sets next cycle and oversize sets (sticky until reset).
  - While force = 1, beats drain cut-through.
  - force clears on the read of a tlast beat.
  - No data is dropped or reordered.
- count:
  - +1 on write only, -1 on read only, unchanged on both or neither.
  - Range 0..DEPTH, never wraps.
- Pointers are log2(DEPTH) bits and wrap naturally at DEPTH.
- Flags are registered and updated from the next count value:
  - almost_full = (DEPTH - count <= ALMOST_FULL_OFFSET)
  - almost_empty = (count <= ALMOST_EMPTY_OFFSET)
- Storage is inferred RAM with a registered read-ahead output stage. Output holds stable while tvalid && !tready (AXI rule).
- aclken low: all registers hold, outputs hold, no handshake counted.
- rst mid-packet: all buffered data is discarded immediately. The partial packet is not replayed.

Test Plan:
- DSIZE = 64, DEPTH = 16, mode 0; write 0..15 with out_tready = 0:
  - tready drops after beat 15; count = 16; almost_full = 1.
  - Reading then returns 0..15 in order; tready returns 1 the cycle after the first read.
- Mode 0, single beat 0xA5 into empty FIFO: tvalid high exactly 1 edge after write, tdata = 0xA5, count back to 0 after read.
- Mode 1, 4-beat packet with tlast on beat 3:
  - tvalid stays 0 until the edge after beat 3, then pkt_count = 1.
  - Beats drain in order; pkt_count = 0 after the tlast read.
- Mode 1, DEPTH = 16, 20-beat packet:
  - At count = 16, force and oversize assert, and beats stream out cut-through.
  - All 20 beats arrive intact; force clears after tlast; oversize stays 1.
- Simultaneous write and read every cycle at count = 8 for 100 cycles: count stays 8, data order preserved, pointers wrap several times.
- Assert rst with count = 5 mid-packet: tvalid = 0, count = 0, pkt_count = 0 and tready = 1 asynchronously. A following packet passes unaffected.

Source files
------------

// File: rtl/axi_stream_cache_param.sv
// axi_stream_cache_param: parametrised AXI-Stream FIFO with fill flags and optional store-and-forward packet mode
module axi_stream_cache_param #(
  parameter int DSIZE               = 64,
  parameter int DEPTH               = 512,
  parameter int PACKET_MODE         = 0,
  parameter int ALMOST_FULL_OFFSET  = 16,
  parameter int ALMOST_EMPTY_OFFSET = 16
) (
  input  logic                       aclk,
  input  logic                       rst,
  input  logic                       aclken,
  input  logic [DSIZE-1:0]           axis_in_tdata,
  input  logic                       axis_in_tlast,
  input  logic                       axis_in_tvalid,
  output logic                       axis_in_tready,
  output logic [DSIZE-1:0]           axis_out_tdata,
  output logic                       axis_out_tlast,
  output logic                       axis_out_tvalid,
  input  logic                       axis_out_tready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       oversize
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DSIZE:0]  mem [DEPTH];
  logic [DSIZE:0]  head_q, head_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d, pkt_q, pkt_d;
  logic            tready_q, tready_d, force_q, force_d, oversize_q, oversize_d;
  logic            af_q, af_d, ae_q, ae_d, wr, rd, full, stuck;
  assign full            = count_q == CW'(DEPTH);
  assign axis_out_tvalid = count_q != '0 && (PACKET_MODE == 0 || pkt_q != '0 || force_q);
  assign wr              = aclken && axis_in_tvalid && tready_q;
  assign rd              = aclken && axis_out_tvalid && axis_out_tready;
  // a full buffer holding no complete packet can never release one: fall back to cut-through
  assign stuck           = PACKET_MODE != 0 && aclken && full && pkt_q == '0;
  always_comb begin
    wr_d       = wr_q + AW'(wr);
    rd_d       = rd_q + AW'(rd);
    count_d    = count_q + CW'(wr) - CW'(rd);
    pkt_d      = PACKET_MODE != 0 ? pkt_q + CW'(wr && axis_in_tlast) - CW'(rd && head_q[DSIZE]) : '0;
    force_d    = PACKET_MODE == 0 ? 1'b0 : (rd && head_q[DSIZE]) ? 1'b0 : stuck ? 1'b1 : force_q;
    oversize_d = oversize_q | stuck;
    tready_d   = count_d != CW'(DEPTH);
    af_d       = (DEPTH - int'(count_d)) <= ALMOST_FULL_OFFSET;
    ae_d       = int'(count_d) <= ALMOST_EMPTY_OFFSET;
    // read-ahead: the incoming beat bypasses the RAM when it lands at the new head
    head_d     = (wr && wr_q == rd_d) ? {axis_in_tlast, axis_in_tdata} : mem[rd_d];
  end
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      pkt_q      <= '0;
      head_q     <= '0;
      tready_q   <= 1'b1;
      force_q    <= 1'b0;
      oversize_q <= 1'b0;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
    end else if (aclken) begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      pkt_q      <= pkt_d;
      head_q     <= head_d;
      tready_q   <= tready_d;
      force_q    <= force_d;
      oversize_q <= oversize_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
    end
  end
  always_ff @(posedge aclk) begin
    if (wr) mem[wr_q] <= {axis_in_tlast, axis_in_tdata};
  end
  assign axis_in_tready = tready_q;
  assign axis_out_tdata = head_q[DSIZE-1:0];
  assign axis_out_tlast = head_q[DSIZE];
  assign count          = count_q;
  assign pkt_count      = pkt_q;
  assign almost_full    = af_q;
  assign almost_empty   = ae_q;
  assign oversize       = oversize_q;
endmodule

// File: tb/tb_axi_stream_cache_param.sv
// tb_axi_stream_cache_param: checks a cut-through and a packet-mode instance against a queue-based model
module tb_axi_stream_cache_param;
  localparam int DW = 64, DEP = 16, AFO = 2, AEO = 2;
  logic clk = 0, rst = 1, en = 1;
  logic [DW-1:0] itd [2], otd [2];
  logic itl [2], itv [2], itr [2], otl [2], otv [2], otr [2], af [2], ae [2], ovs [2];
  logic [4:0] cnt [2], pcnt [2];
  logic [64:0] q0 [$], q1 [$];
  bit mforce = 0, movs = 0, hw, hr;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  axi_stream_cache_param #(.DSIZE(DW), .DEPTH(DEP), .PACKET_MODE(0), .ALMOST_FULL_OFFSET(AFO), .ALMOST_EMPTY_OFFSET(AEO)) u0 (
    .aclk(clk), .rst(rst), .aclken(en), .axis_in_tdata(itd[0]), .axis_in_tlast(itl[0]), .axis_in_tvalid(itv[0]),
    .axis_in_tready(itr[0]), .axis_out_tdata(otd[0]), .axis_out_tlast(otl[0]), .axis_out_tvalid(otv[0]),
    .axis_out_tready(otr[0]), .count(cnt[0]), .pkt_count(pcnt[0]), .almost_full(af[0]), .almost_empty(ae[0]),
    .oversize(ovs[0]));
  axi_stream_cache_param #(.DSIZE(DW), .DEPTH(DEP), .PACKET_MODE(1), .ALMOST_FULL_OFFSET(AFO), .ALMOST_EMPTY_OFFSET(AEO)) u1 (
    .aclk(clk), .rst(rst), .aclken(en), .axis_in_tdata(itd[1]), .axis_in_tlast(itl[1]), .axis_in_tvalid(itv[1]),
    .axis_in_tready(itr[1]), .axis_out_tdata(otd[1]), .axis_out_tlast(otl[1]), .axis_out_tvalid(otv[1]),
    .axis_out_tready(otr[1]), .count(cnt[1]), .pkt_count(pcnt[1]), .almost_full(af[1]), .almost_empty(ae[1]),
    .oversize(ovs[1]));

  function automatic int pkts();
    int n = 0;
    foreach (q1[i]) n += int'(q1[i][64]);
    return n;
  endfunction
  function automatic int msize(int m);
    return m == 0 ? q0.size() : q1.size();
  endfunction
  function automatic bit mvalid(int m);
    return m == 0 ? q0.size() != 0 : (q1.size() != 0 && (pkts() != 0 || mforce));
  endfunction
  function automatic logic [64:0] mhead(int m);
    return m == 0 ? q0[0] : q1[0];
  endfunction

  // one clock: drive at negedge, update model at posedge, return at next negedge
  task automatic tick(input int m, input bit v, input logic [63:0] d, input bit l, input bit r, input bit e,
                      output bit w_o, output bit r_o);
    logic [64:0] p;
    bit c1;
    en = e; itv[m] = v; itd[m] = d; itl[m] = l; otr[m] = r;
    w_o = e && v && msize(m) != DEP;
    r_o = e && r && mvalid(m);
    c1 = e && q1.size() == DEP && pkts() == 0;
    p = '0;
    @(posedge clk);
    if (r_o) begin
      if (m == 0) p = q0.pop_front(); else p = q1.pop_front();
    end
    if (w_o) begin
      if (m == 0) q0.push_back({l, d}); else q1.push_back({l, d});
    end
    if (m == 1 && r_o && p[64]) mforce = 0;
    else if (c1) begin mforce = 1; movs = 1; end
    @(negedge clk);
    itv[m] = 0; otr[m] = 0; en = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (itr[m] !== 1'b1 || otv[m] !== 1'b0 || cnt[m] !== 5'd0 || pcnt[m] !== 5'd0) begin
        n_bad++;
        $display("FAIL reset_state m%0d: tready=%b tvalid=%b count=%0d pkt=%0d, required 1 0 0 0", m, itr[m], otv[m], cnt[m], pcnt[m]);
      end
      n_cmp++;
      if (ae[m] !== 1'b1 || af[m] !== 1'b0 || ovs[m] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_flags m%0d: ae=%b af=%b ovs=%b, required 1 0 0", m, ae[m], af[m], ovs[m]);
      end
    end
    rst = 0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEP; i++) begin
      tick(0, 1, 64'(i), 0, 0, 1, hw, hr);
      n_cmp++;
      if (cnt[0] !== 5'(i + 1) || itr[0] !== (i + 1 != DEP)) begin
        n_bad++;
        $display("FAIL fill_%0d: count=%0d tready=%b, required %0d %b", i, cnt[0], itr[0], i + 1, i + 1 != DEP);
      end
    end
    n_cmp++;
    if (af[0] !== 1'b1 || ae[0] !== 1'b0) begin
      n_bad++; $display("FAIL full_flags: af=%b ae=%b, required 1 0", af[0], ae[0]);
    end
    tick(0, 1, 64'hDEAD, 0, 0, 1, hw, hr);
    tick(0, 0, 64'h0, 0, 1, 0, hw, hr);
    n_cmp++;
    if (cnt[0] !== 5'd16 || itr[0] !== 1'b0 || otd[0] !== 64'd0) begin
      n_bad++; $display("FAIL full_hold: count=%0d tready=%b data=%0h, required 16 0 0", cnt[0], itr[0], otd[0]);
    end
    for (int i = 0; i < DEP; i++) begin
      n_cmp++;
      if (otv[0] !== 1'b1 || otd[0] !== 64'(i)) begin
        n_bad++; $display("FAIL drain_%0d: tvalid=%b data=%0h, required 1 %0h", i, otv[0], otd[0], i);
      end
      tick(0, 0, 64'h0, 0, 1, 1, hw, hr);
      if (i == 0) begin
        n_cmp++;
        if (itr[0] !== 1'b1) begin n_bad++; $display("FAIL tready_after_read: got %b required 1", itr[0]); end
      end
    end
    n_cmp++;
    if (cnt[0] !== 5'd0 || otv[0] !== 1'b0 || ae[0] !== 1'b1) begin
      n_bad++; $display("FAIL drained: count=%0d tvalid=%b ae=%b, required 0 0 1", cnt[0], otv[0], ae[0]);
    end
  endtask

  task automatic test_single();
    n_cmp++;
    if (otv[0] !== 1'b0) begin n_bad++; $display("FAIL single_pre: tvalid=%b required 0", otv[0]); end
    tick(0, 1, 64'hA5, 0, 0, 1, hw, hr);
    n_cmp++;
    if (otv[0] !== 1'b1 || otd[0] !== 64'hA5 || cnt[0] !== 5'd1) begin
      n_bad++; $display("FAIL single_latency: tvalid=%b data=%0h count=%0d, required 1 a5 1", otv[0], otd[0], cnt[0]);
    end
    tick(0, 0, 64'h0, 0, 1, 1, hw, hr);
    n_cmp++;
    if (otv[0] !== 1'b0 || cnt[0] !== 5'd0) begin
      n_bad++; $display("FAIL single_read: tvalid=%b count=%0d, required 0 0", otv[0], cnt[0]);
    end
  endtask

  task automatic test_packet();
    for (int b = 0; b < 4; b++) begin
      tick(1, 1, 64'h100 + 64'(b), b == 3, 0, 1, hw, hr);
      n_cmp++;
      if (otv[1] !== (b == 3) || pcnt[1] !== 5'(b == 3)) begin
        n_bad++; $display("FAIL pkt_wr_%0d: tvalid=%b pkt=%0d, required %b %0d", b, otv[1], pcnt[1], b == 3, b == 3);
      end
    end
    for (int b = 0; b < 4; b++) begin
      n_cmp++;
      if (otv[1] !== 1'b1 || otd[1] !== 64'h100 + 64'(b) || otl[1] !== (b == 3)) begin
        n_bad++; $display("FAIL pkt_rd_%0d: tvalid=%b data=%0h last=%b, required 1 %0h %b", b, otv[1], otd[1], otl[1], 'h100 + b, b == 3);
      end
      tick(1, 0, 64'h0, 0, 1, 1, hw, hr);
    end
    n_cmp++;
    if (pcnt[1] !== 5'd0 || otv[1] !== 1'b0 || cnt[1] !== 5'd0) begin
      n_bad++; $display("FAIL pkt_done: pkt=%0d tvalid=%b count=%0d, required 0 0 0", pcnt[1], otv[1], cnt[1]);
    end
  endtask

  task automatic test_oversize();
    int sent = 0, got = 0;
    for (int c = 0; c < 200 && (sent < 20 || q1.size() != 0); c++) begin
      n_cmp++;
      if (otv[1] !== mvalid(1) || cnt[1] !== 5'(msize(1)) || ovs[1] !== movs || itr[1] !== (msize(1) != DEP)) begin
        n_bad++;
        $display("FAIL ovs_cyc_%0d: tvalid=%b count=%0d ovs=%b tready=%b, required %b %0d %b %b", c, otv[1], cnt[1], ovs[1], itr[1],
                 mvalid(1), msize(1), movs, msize(1) != DEP);
      end
      if (mvalid(1)) begin
        n_cmp++;
        if ({otl[1], otd[1]} !== mhead(1)) begin
          n_bad++; $display("FAIL ovs_data_%0d: got %0h required %0h", c, {otl[1], otd[1]}, mhead(1));
        end
      end
      tick(1, sent < 20, 64'h1000 + 64'(sent), sent == 19, 1, 1, hw, hr);
      sent += int'(hw);
      got += int'(hr);
    end
    n_cmp++;
    if (ovs[1] !== 1'b1 || otv[1] !== 1'b0 || pcnt[1] !== 5'd0 || got != 20) begin
      n_bad++; $display("FAIL ovs_end: ovs=%b tvalid=%b pkt=%0d beats=%0d, required 1 0 0 20", ovs[1], otv[1], pcnt[1], got);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) tick(0, 1, 64'h500 + 64'(i), 0, 0, 1, hw, hr);
    for (int c = 0; c < 100; c++) begin
      n_cmp++;
      if (cnt[0] !== 5'd8 || otv[0] !== 1'b1 || {otl[0], otd[0]} !== mhead(0)) begin
        n_bad++; $display("FAIL b2b_%0d: count=%0d data=%0h, required 8 %0h", c, cnt[0], {otl[0], otd[0]}, mhead(0));
      end
      tick(0, 1, {$urandom, $urandom}, 0, 1, 1, hw, hr);
    end
  endtask

  task automatic test_random(input int m);
    for (int c = 0; c < 300; c++) begin
      tick(m, $urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) != 0, hw, hr);
      n_cmp++;
      if (cnt[m] !== 5'(msize(m)) || otv[m] !== mvalid(m) || itr[m] !== (msize(m) != DEP) ||
          pcnt[m] !== 5'(m == 1 ? pkts() : 0)) begin
        n_bad++;
        $display("FAIL rnd_m%0d_%0d: count=%0d tvalid=%b tready=%b pkt=%0d, required %0d %b %b %0d", m, c, cnt[m], otv[m], itr[m],
                 pcnt[m], msize(m), mvalid(m), msize(m) != DEP, m == 1 ? pkts() : 0);
      end
      n_cmp++;
      if (af[m] !== (DEP - msize(m) <= AFO) || ae[m] !== (msize(m) <= AEO) || (m == 1 && ovs[1] !== movs)) begin
        n_bad++; $display("FAIL rnd_flags_m%0d_%0d: af=%b ae=%b ovs=%b at count %0d", m, c, af[m], ae[m], ovs[m], msize(m));
      end
      if (mvalid(m)) begin
        n_cmp++;
        if ({otl[m], otd[m]} !== mhead(m)) begin
          n_bad++; $display("FAIL rnd_data_m%0d_%0d: got %0h required %0h", m, c, {otl[m], otd[m]}, mhead(m));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    q1.delete();
    for (int i = 0; i < 5; i++) tick(1, 1, 64'h200 + 64'(i), 0, 0, 1, hw, hr);
    #2 rst = 1;
    q0.delete(); q1.delete(); mforce = 0; movs = 0;
    #1;
    n_cmp++;
    if (otv[1] !== 1'b0 || cnt[1] !== 5'd0 || pcnt[1] !== 5'd0 || itr[1] !== 1'b1 || ovs[1] !== 1'b0 || cnt[0] !== 5'd0) begin
      n_bad++; $display("FAIL async_reset: tvalid=%b count=%0d pkt=%0d tready=%b ovs=%b, required 0 0 0 1 0", otv[1], cnt[1], pcnt[1], itr[1], ovs[1]);
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) tick(1, 1, 64'h300 + 64'(i), i == 2, 0, 1, hw, hr);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (otv[1] !== 1'b1 || otd[1] !== 64'h300 + 64'(i) || cnt[1] !== 5'(3 - i)) begin
        n_bad++; $display("FAIL post_reset_%0d: tvalid=%b data=%0h count=%0d, required 1 %0h %0d", i, otv[1], otd[1], cnt[1], 'h300 + i, 3 - i);
      end
      tick(1, 0, 64'h0, 0, 1, 1, hw, hr);
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin itd[m] = '0; itl[m] = 0; itv[m] = 0; otr[m] = 0; end
    test_reset();
    test_fill_drain();
    test_single();
    test_packet();
    test_oversize();
    test_back_to_back();
    test_random(0);
    test_random(1);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
